btb_assoc: RTL and testbench
============================

# btb_assoc

Set-associative, tagged branch target buffer for the fetch stage; the parametrised successor to the direct-mapped, untagged target buffer. Each fetch PC gets a same-cycle lookup that returns a hit flag and a predicted next PC. Resolved branches from execute write back to the buffer: taken branches allocate or refresh an entry, and not-taken branches that hit invalidate it. Replacement fills an invalid way first, otherwise it uses a per-set round-robin pointer.

## Interface
- S_INDEX, default 7: set-index bits; NUM_SETS = 2**S_INDEX.
- WAYS, default 2: associativity; legal values 1, 2, 4, 8.
- Derived, not overridable:
  - ADDR_START = 2.
  - TAG_W = 32 - ADDR_START - S_INDEX.
- Ports:
  - clk  in  1  single clock; all state changes on rising edge.
  - rst  in  1  asynchronous, active-low reset; asserting it clears all state immediately.
  - predict_en  in  1  global write enable (low = pipeline stall); gates every state update.
  - curr_pc  in  32  fetch PC to look up.
  - hit  out  1  curr_pc matches a valid entry.
  - predicted_target  out  32  stored target on hit, else curr_pc + 4.
  - upd_valid  in  1  a branch/jump resolved this cycle.
  - upd_pc  in  32  PC of the resolved instruction.
  - upd_taken  in  1  resolved direction.
  - upd_target  in  32  resolved taken target.

## Operation
- Address split:
  - set = pc[ADDR_START +: S_INDEX].
  - tag = pc[31 : ADDR_START+S_INDEX].
  - pc[1:0] is ignored.
- State, per set s and way w:
  - valid[s][w], tag[s][w] (TAG_W bits), target[s][w] (32 bits).
  - Per set: rr_ptr[s], log2(WAYS) bits; absent when WAYS=1.
- Lookup (combinational, independent of predict_en):
  - Compare curr_pc's tag against all valid ways of its set.
  - hit = OR of the way matches.
  - predicted_target = target of the matching way, else curr_pc + 4 (32-bit wrap; 0xFFFFFFFC + 4 = 0).
  - At most one way can match; update rules never create duplicate tags in a set.
- Update, applied on a rising edge only when predict_en=1 and upd_valid=1. Tag match uses current state.
  - Taken, hit in way w: target[s][w] <= upd_target; rr_ptr unchanged.
  - Taken, miss:
    - Victim = lowest-index invalid way if any, else rr_ptr[s].
    - Write valid=1, tag, target into the victim.
    - rr_ptr[s] advances (mod WAYS) only when the victim was chosen by rr_ptr.
  - Not taken, hit in way w: valid[s][w] <= 0; rr_ptr unchanged.
  - Not taken, miss: no change.
- predict_en=0: no state changes at all, even with upd_valid=1; the update is dropped, not queued.
- WAYS=1: behaves as a tagged direct-mapped BTB; a taken miss always overwrites way 0.

## Timing
- Lookup latency 0: hit and predicted_target settle in the same cycle curr_pc is applied.
- Update becomes visible to lookups the cycle after the qualifying edge.
- Lookup and update in the same cycle (same set, or same PC): the lookup returns pre-update contents. There is no write-through bypass.
- Reset (rst=0):
  - Asynchronously clears all valid bits, rr_ptrs and targets; tags are also cleared.
  - While rst=0 and after release: hit=0 and predicted_target=curr_pc+4 until the first allocation.
- Reset asserted during an update cycle: the reset wins; nothing is written.
- First rising edge after rst deasserts may perform an update.

## Test plan
- Reset: drive rst=0 with garbage on the inputs, then release. Required: curr_pc=0x100 gives hit=0 and predicted_target=0x104.
- Allocate and hit (S_INDEX=2, WAYS=2):
  - Update pc=0x10, taken, target 0x80 with predict_en=1.
  - Next cycle, curr_pc=0x10 gives hit=1, target 0x80.
  - curr_pc=0x30 (same set, different tag) gives hit=0, target 0x34.
- Conflict replacement (set 0, WAYS=2):
  - Allocate taken 0x00→0xA0, 0x10→0xB0, then 0x20→0xC0.
  - Required: 0x20 occupies way 0 (rr_ptr=0 → 1); 0x00 misses, 0x10 still hits 0xB0.
  - A fourth allocation, 0x30, evicts 0x10 from way 1.
- Refresh and invalidate:
  - 0x10 hits with target 0x80; update taken 0x10→0x90. Required: hit, 0x90; rr_ptr unchanged.
  - Then update 0x10 not-taken. Required: next cycle hit=0, predicted_target=0x14.
- Stall and same-cycle hazard:
  - Taken update with predict_en=0. Required: no entry created.
  - Lookup and allocate of the same PC in one cycle. Required: that cycle hit=0, next cycle hit=1.
- Async reset mid-stream: after several allocations, pulse rst low between clock edges. Required: hit drops to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative tagged branch target buffer: same-cycle lookup for fetch,
// execute-side allocate/refresh/invalidate with invalid-first then round-robin replacement.
module btb_assoc #(
    parameter int unsigned S_INDEX = 7,
    parameter int unsigned WAYS    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        predict_en,
    input  logic [31:0] curr_pc,
    output logic        hit,
    output logic [31:0] predicted_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned ADDR_START = 2;
    localparam int unsigned NUM_SETS   = 1 << S_INDEX;
    localparam int unsigned TAG_W      = 32 - ADDR_START - S_INDEX;
    localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic             valid_q  [NUM_SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [NUM_SETS][WAYS];
    logic [31:0]      target_q [NUM_SETS][WAYS];
    logic [WAY_W-1:0] rr_q     [NUM_SETS];

    logic [S_INDEX-1:0] rd_set;
    logic [TAG_W-1:0]   rd_tag;
    logic [S_INDEX-1:0] up_set;
    logic [TAG_W-1:0]   up_tag;
    logic               unused_pc_bits;

    assign rd_set = curr_pc[ADDR_START +: S_INDEX];
    assign rd_tag = curr_pc[31 -: TAG_W];
    assign up_set = upd_pc[ADDR_START +: S_INDEX];
    assign up_tag = upd_pc[31 -: TAG_W];
    assign unused_pc_bits = ^upd_pc[ADDR_START-1:0];

    // Fetch lookup: reads registered state only, so a same-cycle update is not visible
    always_comb begin
        hit              = 1'b0;
        predicted_target = curr_pc + 32'd4;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag)) begin
                hit              = 1'b1;
                predicted_target = target_q[rd_set][w];
            end
        end
    end

    logic             up_hit;
    logic [WAY_W-1:0] up_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;

    // Update-side match and victim selection (lowest invalid way wins over rr pointer)
    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[up_set][w] && (tag_q[up_set][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[up_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q[up_set];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                end
            end
        end else if (predict_en && upd_valid) begin
            if (upd_taken) begin
                if (up_hit) begin
                    target_q[up_set][up_way] <= upd_target;
                end else begin
                    valid_q[up_set][victim]  <= 1'b1;
                    tag_q[up_set][victim]    <= up_tag;
                    target_q[up_set][victim] <= upd_target;
                    if (!inv_found) begin
                        rr_q[up_set] <= (WAYS == 1) ? '0 : rr_q[up_set] + WAY_W'(1);
                    end
                end
            end else if (up_hit) begin
                valid_q[up_set][up_way] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a per-set entry-list reference model.
module tb_btb_assoc;

    localparam int unsigned S_INDEX = 2;
    localparam int unsigned WAYS    = 2;
    localparam int unsigned NSETS   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        predict_en = 1'b0;
    logic [31:0] curr_pc = '0;
    logic        hit;
    logic [31:0] predicted_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    always #5 clk = ~clk;

    btb_assoc #(.S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
        .clk              (clk),
        .rst              (rst),
        .predict_en       (predict_en),
        .curr_pc          (curr_pc),
        .hit              (hit),
        .predicted_target (predicted_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: each set holds WAYS slots keyed by the word address pc[31:2]
    bit          m_v   [NSETS][WAYS];
    logic [29:0] m_key [NSETS][WAYS];
    logic [31:0] m_tgt [NSETS][WAYS];
    int          m_rr  [NSETS];

    function automatic void m_lookup(input logic [31:0] pc, output bit h, output logic [31:0] t);
        int s;
        s = int'((pc >> 2) % NSETS);
        h = 1'b0;
        t = pc + 32'd4;
        for (int w = 0; w < int'(WAYS); w++)
            if (m_v[s][w] && m_key[s][w] == pc[31:2]) begin
                h = 1'b1;
                t = m_tgt[s][w];
            end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(NSETS); s++) begin
                m_rr[s] = 0;
                for (int w = 0; w < int'(WAYS); w++) m_v[s][w] = 1'b0;
            end
        end else if (predict_en && upd_valid) begin
            int s, hw, v;
            s  = int'((upd_pc >> 2) % NSETS);
            hw = -1;
            for (int w = 0; w < int'(WAYS); w++)
                if (m_v[s][w] && m_key[s][w] == upd_pc[31:2]) hw = w;
            if (upd_taken) begin
                if (hw >= 0) m_tgt[s][hw] = upd_target;
                else begin
                    v = -1;
                    for (int w = 0; w < int'(WAYS); w++)
                        if (!m_v[s][w] && v < 0) v = w;
                    if (v < 0) begin
                        v = m_rr[s];
                        m_rr[s] = (m_rr[s] + 1) % int'(WAYS);
                    end
                    m_v[s][v]   = 1'b1;
                    m_key[s][v] = upd_pc[31:2];
                    m_tgt[s][v] = upd_target;
                end
            end else if (hw >= 0) begin
                m_v[s][hw] = 1'b0;
            end
        end
    end

    // Per-cycle compare, mid-cycle so inputs and pre-update state are stable
    always @(negedge clk) begin
        bit          eh;
        logic [31:0] et;
        m_lookup(curr_pc, eh, et);
        chk("cyc_hit", 32'(hit), 32'(eh));
        chk("cyc_target", predicted_target, et);
    end

    task automatic step(input bit pe, input bit uv, input logic [31:0] upc, input bit tk,
                        input logic [31:0] tgt, input logic [31:0] cpc);
        @(posedge clk);
        #1;
        predict_en = pe;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = tk;
        upd_target = tgt;
        curr_pc    = cpc;
        #2;
    endtask

    task automatic look(input logic [31:0] cpc);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, cpc);
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = (($urandom % 8) << 4) | (($urandom % 4) << 2) | ($urandom % 4);
        if ($urandom % 4 == 0) p = p | 32'hFFFF_FF00;
        return p;
    endfunction

    initial begin
        // Reset with garbage on the inputs
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, $urandom, 1'b1, $urandom, $urandom);
        look(32'h100);
        chk("rst_hit", 32'(hit), 32'h0);
        chk("rst_tgt", predicted_target, 32'h104);
        @(posedge clk); #1 rst = 1'b1;
        look(32'h100);
        chk("post_rst_hit", 32'(hit), 32'h0);
        chk("post_rst_tgt", predicted_target, 32'h104);
        look(32'hFFFF_FFFC);
        chk("wrap_tgt", predicted_target, 32'h0);

        // Allocate with same-cycle lookup of the same PC
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h80, 32'h10);
        chk("same_cyc_hit", 32'(hit), 32'h0);
        look(32'h10);
        chk("alloc_hit", 32'(hit), 32'h1);
        chk("alloc_tgt", predicted_target, 32'h80);
        look(32'h30);
        chk("other_tag_hit", 32'(hit), 32'h0);
        chk("other_tag_tgt", predicted_target, 32'h34);

        // Refresh then invalidate
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h90, 32'h10);
        look(32'h10);
        chk("refresh_tgt", predicted_target, 32'h90);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h10);
        look(32'h10);
        chk("inval_hit", 32'(hit), 32'h0);
        chk("inval_tgt", predicted_target, 32'h14);

        // Conflict replacement in set 0
        step(1'b1, 1'b1, 32'h00, 1'b1, 32'hA0, 32'h0);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'hB0, 32'h0);
        step(1'b1, 1'b1, 32'h20, 1'b1, 32'hC0, 32'h0);
        look(32'h00);
        chk("evict0_hit", 32'(hit), 32'h0);
        look(32'h10);
        chk("keep10_tgt", predicted_target, 32'hB0);
        look(32'h20);
        chk("new20_tgt", predicted_target, 32'hC0);
        step(1'b1, 1'b1, 32'h30, 1'b1, 32'hD0, 32'h0);
        look(32'h10);
        chk("evict10_tgt", predicted_target, 32'h14);
        look(32'h30);
        chk("new30_tgt", predicted_target, 32'hD0);

        // Stalled updates are dropped
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h1234, 32'h0);
        step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        look(32'h40);
        chk("stall_alloc_hit", 32'(hit), 32'h0);
        look(32'h20);
        chk("stall_inval_tgt", predicted_target, 32'hC0);

        // Asynchronous reset between edges
        #1 rst = 1'b0;
        #1;
        chk("async_rst_hit", 32'(hit), 32'h0);
        chk("async_rst_tgt", predicted_target, 32'h24);
        @(posedge clk); #1 rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            p = rnd_pc();
            step(($urandom % 5) != 0, ($urandom % 3) != 0, p, ($urandom % 3) != 0, $urandom,
                 ($urandom % 50 == 0) ? 32'hFFFF_FFFC : (($urandom % 2) ? p : rnd_pc()));
            if ($urandom % 250 == 0) begin
                rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        @(posedge clk);
        #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
